// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared constants, FSM state encoding and helpers for the SPI arbiter
package spi_arb_pkg;

   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_DATA_WIDTH     = 12;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_ARB   = 3'd1;
   localparam state_t ST_ISSUE = 3'd2;
   localparam state_t ST_XFER  = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - round-robin search starting one past the last granted requester
import spi_arb_pkg::*;

module spi_rr_arbiter #(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_gnt,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               valid
);

   int cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      cand      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(last_gnt) + k) % NUM_REQ;
         if (!valid && req[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = IDX_W'(cand);
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - shares one SPI master among NUM_REQ requesters; SPI_ARB_TIMEOUT_EN adds a transaction timeout
import spi_arb_pkg::*;

module spi_arbiter #(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            ack,
   output logic [DATA_WIDTH-1:0]         spi_din,
   output logic                          spi_new_data,
   input  logic                          spi_cs,
   output logic                          busy,
   output logic                          err
);

   localparam int IDX_W = idx_width(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("spi_arbiter: parameter out of range");
   end

   state_t             state;
   logic               cs_meta;
   logic               cs_s;
   logic [IDX_W-1:0]   last_gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic [NUM_REQ-1:0] rr_grant;
   logic [IDX_W-1:0]   rr_idx;
   logic               rr_valid;
   logic               tmo_hit;

   spi_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req       (req),
      .last_gnt  (last_gnt),
      .grant     (rr_grant),
      .grant_idx (rr_idx),
      .valid     (rr_valid)
   );

   assign busy = (state != ST_IDLE);

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   logic [TMO_W-1:0] tmo_cnt;
   logic             err_q;

   assign tmo_hit = ((state == ST_ISSUE) || (state == ST_XFER)) &&
                    (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
   assign err     = err_q;

   // Counter is only live while the master owns the bus; any other state re-arms it.
   always_ff @(posedge clk) begin
      if (reset || !((state == ST_ISSUE) || (state == ST_XFER)) || tmo_hit)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         err_q <= 1'b0;
      else
         err_q <= tmo_hit;
   end
`else
   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         gnt          <= '0;
         ack          <= '0;
         spi_din      <= '0;
         spi_new_data <= 1'b0;
         last_gnt     <= IDX_W'(NUM_REQ - 1);
         gnt_idx      <= '0;
         cs_meta      <= 1'b1;
         cs_s         <= 1'b1;
      end else begin
         cs_meta <= spi_cs;
         cs_s    <= cs_meta;
         ack     <= '0;
         case (state)
            ST_IDLE: begin
               if (|req)
                  state <= ST_ARB;
            end
            ST_ARB: begin
               if (rr_valid) begin
                  gnt          <= rr_grant;
                  gnt_idx      <= rr_idx;
                  spi_din      <= req_data[rr_idx*DATA_WIDTH +: DATA_WIDTH];
                  spi_new_data <= 1'b1;
                  state        <= ST_ISSUE;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               if (!cs_s) begin
                  spi_new_data <= 1'b0;
                  state        <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (cs_s) begin
                  ack   <= gnt;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               gnt      <= '0;
               last_gnt <= gnt_idx;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
         // Abort overrides whatever the transaction was about to do this cycle.
         if (tmo_hit) begin
            gnt          <= '0;
            ack          <= '0;
            spi_new_data <= 1'b0;
            last_gnt     <= gnt_idx;
            state        <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed self-checking bench for spi_arbiter with a behavioural SPI master
module tb_spi_arbiter;

   localparam int NR = 4;
   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic [NR-1:0] req;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0] gnt;
   logic [NR-1:0] ack;
   logic [DW-1:0] spi_din;
   logic          spi_new_data;
   logic          spi_cs;
   logic          busy;
   logic          err;

   int total = 0;
   int bad   = 0;

   spi_arbiter #(
      .NUM_REQ        (NR),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_data     (req_data),
      .gnt          (gnt),
      .ack          (ack),
      .spi_din      (spi_din),
      .spi_new_data (spi_new_data),
      .spi_cs       (spi_cs),
      .busy         (busy),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_word(input int i, input logic [DW-1:0] w);
      req_data[i*DW +: DW] = w;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_nd(input logic lvl);
      int n;
      n = 0;
      while (spi_new_data !== lvl && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("nd_wait", 32'(spi_new_data), 32'(lvl));
   endtask

   // Master model: loops din back as dout, holds cs low a few cycles, then releases.
   task automatic run_xfer(input int idx, input logic [DW-1:0] word, input bit drop);
      logic [DW-1:0] dout;
      int n;
      wait_nd(1'b1);
      check("gnt", 32'(gnt), 32'(1 << idx));
      check("din", 32'(spi_din), 32'(word));
      repeat (3) @(negedge clk);
      check("nd_hold", 32'(spi_new_data), 32'd1);
      check("din_hold", 32'(spi_din), 32'(word));
      spi_cs = 1'b0;
      dout   = spi_din;
      wait_nd(1'b0);
      check("dout", 32'(dout), 32'(word));
      if (drop) req[idx] = 1'b0;
      repeat (4) @(negedge clk);
      check("gnt_xfer", 32'(gnt), 32'(1 << idx));
      check("ack_early", 32'(ack), 32'd0);
      spi_cs = 1'b1;
      n = 0;
      while (ack == '0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ack", 32'(ack), 32'(1 << idx));
      check("ack_gnt", 32'(gnt), 32'(1 << idx));
      @(negedge clk);
      check("ack_pulse", 32'(ack), 32'd0);
      check("gnt_clear", 32'(gnt), 32'd0);
      check("nd_gap", 32'(spi_new_data), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset    = 1'b1;
      req      = '0;
      req_data = '0;
      spi_cs   = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_nd", 32'(spi_new_data), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_din", 32'(spi_din), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Single request from requester 0
      set_word(0, 12'hA5C);
      req = 4'b0001;
      run_xfer(0, 12'hA5C, 1'b0);
      req = '0;
      repeat (2) @(negedge clk);
      check("single_busy", 32'(busy), 32'd0);

      // Simultaneous req0/req2 after last_gnt=0: 2 then 0
      set_word(0, 12'h123);
      set_word(2, 12'h456);
      req = 4'b0101;
      run_xfer(2, 12'h456, 1'b0);
      req[2] = 1'b0;
      run_xfer(0, 12'h123, 1'b0);
      req = '0;
      repeat (2) @(negedge clk);

      // All requesting from a fresh pointer: 0,1,2,3,0
      do_reset();
      for (int i = 0; i < NR; i++) set_word(i, DW'(12'h100 + i));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) run_xfer(k % NR, DW'(12'h100 + (k % NR)), 1'b0);
      req = '0;
      repeat (2) @(negedge clk);

      // Requester 1 drops req mid-transfer; ack still pulses
      set_word(1, 12'h7E1);
      req = 4'b0010;
      run_xfer(1, 12'h7E1, 1'b1);
      repeat (2) @(negedge clk);
      check("drop_busy", 32'(busy), 32'd0);

      // Reset while in XFER abandons the transaction
      set_word(2, 12'h3C3);
      req = 4'b0100;
      wait_nd(1'b1);
      spi_cs = 1'b0;
      wait_nd(1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_xfer_ack0", 32'(ack), 32'd0);
      spi_cs = 1'b1;
      req    = '0;
      @(negedge clk);
      check("rst_xfer_ack1", 32'(ack), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_xfer_gnt", 32'(gnt), 32'd0);
      check("rst_xfer_busy", 32'(busy), 32'd0);
      check("rst_xfer_err", 32'(err), 32'd0);
      set_word(3, 12'hBEE);
      req = 4'b1000;
      run_xfer(3, 12'hBEE, 1'b0);
      req = '0;
      repeat (2) @(negedge clk);

      // cs stuck high
      set_word(0, 12'h0F0);
      req = 4'b0001;
      wait_nd(1'b1);
`ifdef SPI_ARB_TIMEOUT_EN
      n = 0;
      while (err !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("tmo_err", 32'(err), 32'd1);
      check("tmo_cycles", 32'(n), 32'd64);
      check("tmo_ack", 32'(ack), 32'd0);
      check("tmo_gnt", 32'(gnt), 32'd0);
      check("tmo_nd", 32'(spi_new_data), 32'd0);
      req = '0;
      @(negedge clk);
      check("tmo_err_pulse", 32'(err), 32'd0);
      set_word(1, 12'h5A5);
      req = 4'b0011;
      run_xfer(1, 12'h5A5, 1'b0);
      req = '0;
      repeat (2) @(negedge clk);
`else
      n = 0;
      repeat (100) begin
         @(negedge clk);
         if (err !== 1'b0) n++;
      end
      check("stuck_err", 32'(n), 32'd0);
      check("stuck_busy", 32'(busy), 32'd1);
      check("stuck_nd", 32'(spi_new_data), 32'd1);
      check("stuck_gnt", 32'(gnt), 32'd1);
      req = '0;
      do_reset();
      @(negedge clk);
      check("stuck_rst_busy", 32'(busy), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one SPI master (2..8).
REQ-002 Parameter: DATA_WIDTH, default 12, SPI word width, equal to the master's din width.
REQ-003 Parameter: TIMEOUT_CYCLES, default 1024, clk cycles allowed per transaction before abort.
REQ-004 Port: clk  input  1  system clock; all logic is on posedge clk.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: req  input  NUM_REQ  per-requester request level, held high until ack.
REQ-007 Port: req_data  input  NUM_REQ*DATA_WIDTH  flattened words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port: gnt  output  NUM_REQ  one-hot grant, high for the whole owned transaction.
REQ-009 Port: ack  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-010 Port: spi_din  output  DATA_WIDTH  word driven to the master's din.
REQ-011 Port: spi_new_data  output  1  start strobe to the master's new_data.
REQ-012 Port: spi_cs  input  1  master chip-select, active low, asynchronous to clk (sclk domain).
REQ-013 Port: busy  output  1  high in any state other than IDLE.
REQ-014 Port: err  output  1  one-cycle pulse on timeout abort (SPI_ARB_TIMEOUT_EN only; otherwise tied 0).

Function
REQ-015 spi_cs is synchronised through two clk flops before use; only the synchronised value (cs_s) drives the FSM.
REQ-016 FSM states: IDLE, ARB, ISSUE, XFER, DONE.
REQ-017 IDLE -> ARB when any req bit is high; otherwise stay in IDLE.
REQ-018 ARB, one cycle: round-robin select of the first asserted req starting at last_gnt+1 modulo NUM_REQ; register gnt and spi_din; -> ISSUE.
REQ-019 ARB with req dropped to all-zero -> IDLE, with no grant and no pointer update.
REQ-020 ISSUE: spi_new_data=1 and spi_din held stable until cs_s==0, then -> XFER with spi_new_data=0 in the same edge.
REQ-021 XFER: wait for cs_s==1, then -> DONE.
REQ-022 DONE, one cycle: ack[granted]=1, last_gnt=granted index, gnt cleared, -> IDLE.
REQ-023 Minimum re-grant spacing is one IDLE cycle, so the master sees new_data low between words.
REQ-024 Requester dropping req after ARB does not abort the transaction; ack is still pulsed.
REQ-025 Requests arriving during a transaction are queued by level only; the arbiter does not store them.
REQ-026 gnt is one-hot or zero at all times; ack is asserted only in DONE.

Reset
REQ-027 On reset: state=IDLE; gnt, ack, spi_new_data, err, busy=0; spi_din=0; last_gnt=NUM_REQ-1 (requester 0 wins first); timeout counter=0; sync flops=1.
REQ-028 Reset mid-transaction abandons the transaction with no ack and no err; the master is reset by the same signal.

Configuration
REQ-029 With macro SPI_ARB_TIMEOUT_EN defined, a counter runs in ISSUE/XFER.
REQ-030 When that counter reaches TIMEOUT_CYCLES-1: err pulse, gnt cleared, spi_new_data=0, no ack, pointer advanced past the granted requester, -> IDLE.
REQ-031 Without SPI_ARB_TIMEOUT_EN: no counter is built, err is constant 0, and ISSUE/XFER wait indefinitely.

Structure
REQ-032 Package spi_arb_pkg holds the state_t enum and the default parameter constants.
REQ-033 Sub-module spi_rr_arbiter (req, last_gnt -> one-hot next grant and index) holds the round-robin search; the FSM and cs synchroniser stay in spi_arbiter.

Verification
REQ-034 Single request: req=4'b0001, word 12'hA5C -> gnt[0], new_data until cs low; slave dout=12'hA5C; ack[0] one pulse; busy low after.
REQ-035 All requesting: req=4'b1111 held -> grant order 0,1,2,3,0 across five transactions; each ack matches its gnt.
REQ-036 Simultaneous: req0 and req2 rise on the same cycle after last_gnt=0 -> req2 is served first, then req0.
REQ-037 Mid-transfer drop: req1 deasserts during XFER -> transfer completes and ack[1] still pulses.
REQ-038 Reset in XFER: reset for 2 cycles -> gnt=0, no ack; next req3 alone is granted cleanly with last_gnt=3.
REQ-039 With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64, spi_cs stuck high -> err pulses 64 cycles after ISSUE entry, with no ack.
